// File: rtl/periph_pkg.sv
// Shared register map and reset constants for the core's peripheral register bus.
// Latency: none (declarations only).
// Backpressure: none; peripherals on this bus accept every access.
package periph_pkg;

    // Byte offsets of the machine timer registers.
    localparam logic [4:0] MTIME_LO     = 5'h00;
    localparam logic [4:0] MTIME_HI     = 5'h04;
    localparam logic [4:0] MTIMECMP_LO  = 5'h08;
    localparam logic [4:0] MTIMECMP_HI  = 5'h0C;
    localparam logic [4:0] TIMER_CTRL   = 5'h10;
    localparam logic [4:0] TIMER_STATUS = 5'h14;

    // Field positions inside the ctrl register.
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 8;

    // Compare starts at the maximum so no interrupt fires before software sets it.
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock into a one-cycle tick every div+1 enabled cycles.
// Latency: tick is combinational from pcnt; pcnt updates each edge.
// Backpressure: none; clear restarts the count and swallows a coincident tick.
module timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  clear,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;
    logic                  at_div;

    assign at_div = (pcnt_q == div);
    assign tick   = en && at_div && !clear;

    // Count enabled cycles, wrapping at div; a ctrl write forces a fresh start.
    always_comb begin
        pcnt_d = pcnt_q;
        if (clear) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = at_div ? '0 : pcnt_q + PRESCALE_W'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp with prescaler, hi snapshot and level interrupt.
// Latency: read data one cycle after addr; intr_timer one edge after the compare holds.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
module machine_timer
    import periph_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        intr_timer
);

    logic [4:0]            addr_q;
    logic [63:0]           mtime_q,     mtime_d;
    logic [63:0]           mtimecmp_q,  mtimecmp_d;
    logic                  en_q,        en_d;
    logic [PRESCALE_W-1:0] div_q,       div_d;
    logic [31:0]           hi_shadow_q, hi_shadow_d;
    logic                  intr_q;

    logic                  tick;
    logic                  ctrl_wr;
    logic                  cmp_hit;
    logic [31:0]           ctrl_rd;

    assign ctrl_wr    = write_en && (addr_q == TIMER_CTRL);
    assign cmp_hit    = (mtime_q >= mtimecmp_q);
    assign intr_timer = intr_q;

    timer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en_q),
        .div   (div_q),
        .clear (ctrl_wr),
        .tick  (tick)
    );

    // Next-state for the register file: counter advance, bus writes and hi snapshot.
    always_comb begin
        mtime_d     = mtime_q + {63'd0, tick};
        mtimecmp_d  = mtimecmp_q;
        en_d        = en_q;
        div_d       = div_q;
        hi_shadow_d = hi_shadow_q;
        if (write_en) begin
            case (addr_q)
                // A half-write wins over a tick; the other half keeps its pre-tick value.
                MTIME_LO:    mtime_d = {mtime_q[63:32], data_in};
                MTIME_HI:    mtime_d = {data_in, mtime_q[31:0]};
                MTIMECMP_LO: mtimecmp_d[31:0]  = data_in;
                MTIMECMP_HI: mtimecmp_d[63:32] = data_in;
                TIMER_CTRL: begin
                    en_d  = data_in[CTRL_EN_BIT];
                    div_d = data_in[CTRL_DIV_LSB +: PRESCALE_W];
                end
                default: ;
            endcase
        end
        // Reading lo freezes hi so a following hi read is coherent with it.
        if (read_en && (addr_q == MTIME_LO)) begin
            hi_shadow_d = mtime_q[63:32];
        end
    end

    // Assemble ctrl readback with unused bits forced to zero.
    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_EN_BIT] = en_q;
        ctrl_rd[CTRL_DIV_LSB +: PRESCALE_W] = div_q;
    end

    // Read mux driven by the registered address.
    always_comb begin
        data_out = '0;
        case (addr_q)
            MTIME_LO:     data_out = mtime_q[31:0];
            MTIME_HI:     data_out = hi_shadow_q;
            MTIMECMP_LO:  data_out = mtimecmp_q[31:0];
            MTIMECMP_HI:  data_out = mtimecmp_q[63:32];
            TIMER_CTRL:   data_out = ctrl_rd;
            TIMER_STATUS: data_out = {31'd0, cmp_hit};
            default:      data_out = '0;
        endcase
    end

    // State registers; reset discards any write or tick in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q      <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= MTIMECMP_RESET;
            en_q        <= 1'b0;
            div_q       <= '0;
            hi_shadow_q <= '0;
            intr_q      <= 1'b0;
        end else begin
            addr_q      <= addr;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            en_q        <= en_d;
            div_q       <= div_d;
            hi_shadow_q <= hi_shadow_d;
            intr_q      <= en_q && cmp_hit;
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: directed scenarios plus random bus traffic.
// Latency: checks outputs on the falling edge after each rising edge.
// Backpressure: not applicable; the bench drives one access per cycle.
module tb_machine_timer;

    localparam int PW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  addr;
    logic        write_en;
    logic        read_en;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        intr_timer;

    always #5 clk = ~clk;

    machine_timer #(.PRESCALE_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .write_en   (write_en),
        .read_en    (read_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .intr_timer (intr_timer)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Reference model state: the timer described by its programmer-visible rules.
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp;
    bit            m_en;
    logic [PW-1:0] m_div;
    longint        m_k;       // enabled cycles since the last ctrl write or reset
    logic [31:0]   m_shadow;
    logic [4:0]    m_addr;
    bit            m_intr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [31:0] c;
        c = '0;
        case (m_addr)
            5'h00: c = m_mtime[31:0];
            5'h04: c = m_shadow;
            5'h08: c = m_cmp[31:0];
            5'h0C: c = m_cmp[63:32];
            5'h10: begin
                c[0] = m_en;
                c[8 +: PW] = m_div;
            end
            5'h14: c = {31'd0, (m_mtime >= m_cmp)};
            default: c = '0;
        endcase
        return c;
    endfunction

    // Advance the model by one clock edge using the inputs applied during the cycle.
    task automatic model_update();
        bit          ctrl_wr;
        bit          tk;
        bit          nintr;
        logic [63:0] nt;
        if (!reset) begin
            m_mtime  = '0;
            m_cmp    = '1;
            m_en     = 1'b0;
            m_div    = '0;
            m_k      = 0;
            m_shadow = '0;
            m_addr   = '0;
            m_intr   = 1'b0;
        end else begin
            ctrl_wr = write_en && (m_addr == 5'h10);
            tk      = m_en && !ctrl_wr && ((m_k % (longint'(m_div) + 1)) == longint'(m_div));
            nintr   = m_en && (m_mtime >= m_cmp);
            nt      = m_mtime + (tk ? 64'd1 : 64'd0);
            if (read_en && m_addr == 5'h00) m_shadow = m_mtime[63:32];
            if (ctrl_wr) m_k = 0;
            else if (m_en) m_k++;
            if (write_en) begin
                case (m_addr)
                    5'h00: nt = {m_mtime[63:32], data_in};
                    5'h04: nt = {data_in, m_mtime[31:0]};
                    5'h08: m_cmp[31:0]  = data_in;
                    5'h0C: m_cmp[63:32] = data_in;
                    5'h10: begin
                        m_en  = data_in[0];
                        m_div = data_in[8 +: PW];
                    end
                    default: ;
                endcase
            end
            m_mtime = nt;
            m_addr  = addr;
            m_intr  = nintr;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (chk_on) begin
            check("model_rdata", {32'd0, data_out}, {32'd0, exp_rdata()});
            check("model_intr", {63'd0, intr_timer}, {63'd0, m_intr});
        end
    endtask

    task automatic set_bus(input logic [4:0] a, input bit we, input bit re, input logic [31:0] d);
        addr     = a;
        write_en = we;
        read_en  = re;
        data_in  = d;
    endtask

    // Address cycle then strobe cycle; nxt is presented during the strobe.
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [4:0] nxt);
        set_bus(a, 1'b0, 1'b0, 32'd0);
        cycle();
        set_bus(nxt, 1'b1, 1'b0, d);
        cycle();
        set_bus(nxt, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        set_bus(a, 1'b0, 1'b0, 32'd0);
        cycle();
        d = data_out;
        set_bus(a, 1'b0, 1'b1, 32'd0);
        cycle();
        set_bus(a, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_bus(5'h00, 1'b0, 1'b0, 32'd0);
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [4:0]  a;
        bit          we;
        bit          re;
        logic [31:0] d;

        // Reset and register readback.
        reset = 1'b0;
        set_bus(5'h00, 1'b0, 1'b0, 32'd0);
        cycle();
        cycle();
        reset  = 1'b1;
        chk_on = 1'b1;
        check("rst_intr", {63'd0, intr_timer}, 64'd0);
        check("rst_dout", {32'd0, data_out}, 64'd0);
        rd(5'h00, v); check("rst_mtime_lo", {32'd0, v}, 64'd0);
        rd(5'h04, v); check("rst_mtime_hi", {32'd0, v}, 64'd0);
        rd(5'h08, v); check("rst_cmp_lo", {32'd0, v}, 64'hFFFF_FFFF);
        rd(5'h0C, v); check("rst_cmp_hi", {32'd0, v}, 64'hFFFF_FFFF);
        rd(5'h10, v); check("rst_ctrl", {32'd0, v}, 64'd0);
        rd(5'h14, v); check("rst_status", {32'd0, v}, 64'd0);
        repeat (100) cycle();
        rd(5'h00, v); check("disabled_mtime", {32'd0, v}, 64'd0);

        // div=3: one tick every 4 cycles.
        wr(5'h10, 32'h0000_0301, 5'h00);
        for (int k = 1; k <= 40; k++) begin
            cycle();
            check("div3_count", {32'd0, data_out}, 64'(k / 4));
        end
        cycle();
        cycle();
        // This ctrl write lands on a tick cycle: the tick is dropped and counting restarts.
        wr(5'h10, 32'h0000_0301, 5'h00);
        check("ctrl_suppress", {32'd0, data_out}, 64'd10);
        for (int j = 1; j <= 4; j++) begin
            cycle();
            check("ctrl_restart", {32'd0, data_out}, (j < 4) ? 64'd10 : 64'd11);
        end

        // Compare to interrupt latency with div=0.
        do_reset();
        wr(5'h0C, 32'd0, 5'h00);
        wr(5'h08, 32'd20, 5'h00);
        wr(5'h10, 32'h0000_0001, 5'h00);
        for (int k = 1; k <= 22; k++) begin
            cycle();
            check("cmp_mtime", {32'd0, data_out}, 64'(k));
            check("cmp_intr", {63'd0, intr_timer}, (k >= 21) ? 64'd1 : 64'd0);
        end
        wr(5'h08, 32'd1000, 5'h00);
        check("cmp_move_edge", {63'd0, intr_timer}, 64'd1);
        cycle();
        check("cmp_move_fall", {63'd0, intr_timer}, 64'd0);

        // Coherent lo/hi read across the 32-bit carry.
        do_reset();
        wr(5'h00, 32'hFFFF_FFFE, 5'h00);
        wr(5'h10, 32'h0000_0001, 5'h00);
        set_bus(5'h04, 1'b0, 1'b1, 32'd0);
        lo = data_out;
        cycle();
        set_bus(5'h04, 1'b0, 1'b0, 32'd0);
        hi = data_out;
        check("snap_lo", {32'd0, lo}, 64'hFFFF_FFFE);
        check("snap_hi", {32'd0, hi}, 64'd0);
        set_bus(5'h00, 1'b0, 1'b0, 32'd0);
        cycle();
        set_bus(5'h04, 1'b0, 1'b1, 32'd0);
        lo = data_out;
        cycle();
        set_bus(5'h04, 1'b0, 1'b0, 32'd0);
        hi = data_out;
        check("snap2_lo", {32'd0, lo}, 64'd0);
        check("snap2_hi", {32'd0, hi}, 64'd1);

        // 64-bit wrap with mtimecmp = 0 keeps the interrupt asserted.
        do_reset();
        wr(5'h0C, 32'd0, 5'h00);
        wr(5'h08, 32'd0, 5'h00);
        wr(5'h00, 32'hFFFF_FFFF, 5'h00);
        wr(5'h04, 32'hFFFF_FFFF, 5'h00);
        wr(5'h10, 32'h0000_0001, 5'h00);
        check("wrap_pre_intr", {63'd0, intr_timer}, 64'd0);
        check("wrap_pre_lo", {32'd0, data_out}, 64'hFFFF_FFFF);
        cycle();
        check("wrap_lo", {32'd0, data_out}, 64'd0);
        check("wrap_intr", {63'd0, intr_timer}, 64'd1);
        cycle();
        check("wrap_intr_hold", {63'd0, intr_timer}, 64'd1);

        // Reset while interrupting with a write to mtimecmp_hi in flight.
        set_bus(5'h0C, 1'b0, 1'b0, 32'd0);
        cycle();
        set_bus(5'h0C, 1'b1, 1'b0, 32'h0000_1234);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        set_bus(5'h00, 1'b0, 1'b0, 32'd0);
        check("rstmid_intr", {63'd0, intr_timer}, 64'd0);
        check("rstmid_dout", {32'd0, data_out}, 64'd0);
        cycle();
        check("rstmid_intr_next", {63'd0, intr_timer}, 64'd0);
        rd(5'h0C, v); check("rstmid_cmp_hi", {32'd0, v}, 64'hFFFF_FFFF);
        rd(5'h08, v); check("rstmid_cmp_lo", {32'd0, v}, 64'hFFFF_FFFF);
        rd(5'h00, v); check("rstmid_mtime", {32'd0, v}, 64'd0);
        rd(5'h10, v); check("rstmid_ctrl", {32'd0, v}, 64'd0);

        // Random traffic against the model, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            case ($urandom_range(0, 8))
                0: a = 5'h00;
                1: a = 5'h04;
                2: a = 5'h08;
                3: a = 5'h0C;
                4: a = 5'h10;
                5: a = 5'h14;
                6: a = 5'h18;
                7: a = 5'h1C;
                default: a = 5'(($urandom_range(0, 7) * 4) + 1);
            endcase
            we = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: d = 32'($urandom_range(0, 400));
                1: d = 32'hFFFF_FFFF;
                2: d = $urandom;
                default: d = (32'($urandom_range(0, 3)) << 8) | 32'd1;
            endcase
            set_bus(a, we, re, d);
            cycle();
        end
        reset = 1'b1;
        set_bus(5'h00, 1'b0, 1'b0, 32'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped RISC-V machine timer holding a 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register, with a programmable prescaler. It sits directly upstream of the CSR unit and drives that unit's level-sensitive `intr_timer` input, which feeds `mip[7]`. The block sits on the core's peripheral register bus and uses the same address-registered access scheme as the CSR unit.

## Interface
- `PRESCALE_W`, default 8: width of the prescaler divisor field and counter.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-low.
- `addr`  in  5: byte address of the register, sampled into `addr_reg` every cycle.
- `write_en`  in  1: write strobe, qualified against `addr_reg`.
- `read_en`  in  1: read strobe, qualified against `addr_reg`; used only for the snapshot side effect.
- `data_in`  in  32: write data, consumed in the same cycle as `write_en`.
- `data_out`  out  32: read data, combinational from `addr_reg`.
- `intr_timer`  out  1: registered level interrupt to the CSR unit.

## Operation
- Register map, decoded from `addr_reg`:
  - 0x00 `mtime_lo`: R/W.
  - 0x04 `mtime_hi`: W writes the counter; R returns the snapshot.
  - 0x08 `mtimecmp_lo`: R/W.
  - 0x0C `mtimecmp_hi`: R/W.
  - 0x10 `ctrl`: R/W. Bit 0 = `en`; bits [8+PRESCALE_W-1:8] = `div`; other bits read 0.
  - 0x14 `status`: RO. Bit 0 = raw compare result (`mtime >= mtimecmp`, unsigned 64-bit).
  - Any other address: read returns 0; write is ignored.
- Prescaler: counter `pcnt` runs only while `en` = 1.
  - When `pcnt == div`: emit `tick` and clear `pcnt` to 0. Otherwise increment `pcnt`.
  - `div` = 0 gives a tick every cycle. `div` = N gives a tick every N+1 cycles.
- On `tick`, `mtime` increments by 1 and wraps from 2^64-1 to 0 with no flag.
- Snapshot rule:
  - `read_en` with `addr_reg` = 0x00 latches `mtime[63:32]` into `hi_shadow`.
  - Reads of 0x04 return `hi_shadow`.
  - Reading lo then hi therefore yields a coherent 64-bit value.
- Writes to `mtime_lo` or `mtime_hi` replace only that half.
- Writes to `ctrl` clear `pcnt` to 0.
- `intr_timer <= en && (mtime >= mtimecmp)`, with both operands taken as register values at the clock edge.
  - The interrupt is cleared only by moving `mtimecmp` above `mtime`, by writing `mtime`, or by clearing `en`.
  - There is no W1C.
- Simultaneous events:
  - A write to an `mtime` half in the same cycle as a `tick` takes the written value for that half. The other half keeps its pre-tick value, with no carry applied.
  - A write to `ctrl` in a tick cycle suppresses that tick.

## Timing
- Reset values: `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `ctrl` = 0 (disabled, `div` = 0), `pcnt` = 0, `hi_shadow` = 0, `addr_reg` = 0, `intr_timer` = 0.
  - After reset, `data_out` reads the `mtime_lo` value, which is 0.
- Access protocol:
  - Cycle N: present `addr`.
  - Cycle N+1: `data_out` is valid, and `write_en`/`read_en`/`data_in` take effect at the end of N+1.
- With `div` = 0 and `en` = 1, `mtime` increments on every edge.
- Compare-to-interrupt latency: `intr_timer` rises on the edge after `mtime` first satisfies `mtime >= mtimecmp`.
  - `mip[7]` in the CSR unit follows one cycle later.
- A write to `mtimecmp` takes effect on the register at edge E. `intr_timer` reflects the new compare at edge E+1.
- Reset asserted mid-count:
  - All state returns to reset values on that edge.
  - Any pending `tick` or write in that cycle is discarded.
  - `intr_timer` is 0 on the following cycle.

## Structure
- Shared package `periph_pkg`:
  - Register offset localparams: `MTIME_LO`, `MTIME_HI`, `MTIMECMP_LO`, `MTIMECMP_HI`, `TIMER_CTRL`, `TIMER_STATUS`.
  - `CTRL_EN_BIT` and `CTRL_DIV_LSB`.
  - `MTIMECMP_RESET` constant.
- Sub-module `timer_prescaler`:
  - Ports: `clk`, `reset`, `en`, `div`, `clear` → `tick`.
  - Holds `pcnt`.
- The 64-bit comparator, register file and snapshot logic live in `machine_timer`.

## Test plan
- Reset, then read every register → `mtime` = 0, `mtimecmp` = all ones, `ctrl` = 0, `status` = 0, `intr_timer` = 0. Hold 100 cycles disabled → `mtime` stays 0.
- Set `ctrl` = {`div`=3, `en`=1}; run 40 cycles → `mtime` = 10, with ticks spaced exactly every 4 cycles. Rewrite `ctrl` mid-count → `pcnt` restarts at 0.
- `div` = 0, `mtimecmp` = 20 → `intr_timer` rises on the edge after `mtime` = 20. Write `mtimecmp` = 1000 → `intr_timer` falls one cycle after the write edge.
- Write `mtime` = 64'h0000_0000_FFFF_FFFE with `en` = 1, `div` = 0; read lo then hi across the carry → hi matches the snapshot taken at the lo read, never a torn value. The next lo/hi pair reads `mtime_hi` = 1.
- Write `mtime` = all ones and `mtimecmp` = 0 → after one tick `mtime` wraps to 0 and `intr_timer` stays 1, since 0 >= 0.
- Assert `reset` while `intr_timer` = 1 and a write is in flight → the write is lost, all registers are at reset values, and `intr_timer` = 0 on the next cycle.
